// File: rtl/bit_64_adder.sv
// 64-bit registered adder built from 16 four-bit carry-lookahead groups with rippled group carries.
// Optional zero flag output enabled by defining BIT_64_ADDER_ZERO_FLAG_EN.
module bit_64_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
`ifdef BIT_64_ADDER_ZERO_FLAG_EN
  output logic        zero,
`endif
  output logic [63:0] sum,
  output logic        carry,
  output logic        overflow
);

  logic [63:0] g;
  logic [63:0] p;
  logic [64:0] c;
  logic [63:0] sum_d;
  logic        carry_d;
  logic        overflow_d;
  logic [63:0] sum_q;
  logic        carry_q;
  logic        overflow_q;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = 1'b0;

  // Each group resolves its internal carries from its own cin in two gate levels.
  for (genvar k = 0; k < 16; k++) begin : g_cla
    localparam int B = 4 * k;
    logic ci;
    assign ci = c[B];
    assign c[B+1] = g[B] | (p[B] & ci);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & ci);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & ci);
  end

  assign sum_d      = p ^ c[63:0];
  assign carry_d    = c[64];
  assign overflow_d = c[63] ^ c[64];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

`ifdef BIT_64_ADDER_ZERO_FLAG_EN
  logic zero_d;
  logic zero_q;

  // Reset value tracks the cleared sum.
  assign zero_d = (sum_d == 64'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b1;
    else     zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_bit_64_adder.sv
// Self-checking bench for bit_64_adder: directed vector table, reset/timing sequences, random stream.
module tb_bit_64_adder;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] sum;
  logic        carry;
  logic        overflow;
`ifdef BIT_64_ADDER_ZERO_FLAG_EN
  logic        zero;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  bit_64_adder dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
`ifdef BIT_64_ADDER_ZERO_FLAG_EN
    .zero     (zero),
`endif
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  function automatic void model(input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] wide;
    wide = {1'b0, x} + {1'b0, y};
    s    = wide[63:0];
    co   = wide[64];
    ov   = (x[63] == y[63]) && (s[63] != x[63]);
  endfunction

  task automatic check(input string nm, input logic [63:0] es, input logic ec, input logic eo);
    n_cmp++;
    if (sum !== es || carry !== ec || overflow !== eo) begin
      n_mis++;
      $display("FAIL %s: got sum=%h carry=%b ovf=%b, want sum=%h carry=%b ovf=%b",
               nm, sum, carry, overflow, es, ec, eo);
    end
`ifdef BIT_64_ADDER_ZERO_FLAG_EN
    n_cmp++;
    if (zero !== (es == 64'd0)) begin
      n_mis++;
      $display("FAIL %s zero: got %b, want %b", nm, zero, (es == 64'd0));
    end
`endif
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    logic [63:0] es;
    logic        ec;
    logic        eo;

    vecs[0] = '{"7+1",       64'd7,                  64'd1,                  64'd8,                  1'b0, 1'b0};
    vecs[1] = '{"0+0",       64'd0,                  64'd0,                  64'd0,                  1'b0, 1'b0};
    vecs[2] = '{"-7+-3",     64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1, 1'b0};
    vecs[3] = '{"max+1",     64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                  64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{"max+max",   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1};
    vecs[5] = '{"0+pattern", 64'd0,                  64'h1334_5678_4ACB_CF77, 64'h1334_5678_4ACB_CF77, 1'b0, 1'b0};
    vecs[6] = '{"wrap",      64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd0,                  1'b1, 1'b0};
    vecs[7] = '{"min+min",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,                  1'b1, 1'b1};
    vecs[8] = '{"ripple16",  64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[9] = '{"-1+-1",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};

    a   = 64'd5;
    b   = 64'd9;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_state", 64'd0, 1'b0, 1'b0);

    // Held reset ignores clock edges.
    repeat (3) @(posedge clk);
    #1 check("reset_held", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("first_after_reset", 64'd14, 1'b0, 1'b0);

    // Mid-stream async reset clears outputs before any edge.
    #2 rst = 1'b1;
    #1 check("async_reset", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(64'd20, 64'd22);
    check("post_reset_stream", 64'd42, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].sum, vecs[i].carry, vecs[i].ovf);
    end

    // Input change between edges must not reach the outputs.
    apply(64'd1, 64'd2);
    #2 a = 64'd100;
    #1 check("hold_between_edges", 64'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("new_after_edge", 64'd102, 1'b0, 1'b0);

    // Back-to-back random stream with corner biasing.
    for (int i = 0; i < 300; i++) begin
      logic [63:0] x;
      logic [63:0] y;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: y = -x;
        1: begin x[63] = 1'b0; y[63] = 1'b0; x[62] = 1'b1; y[62] = 1'b1; end
        2: begin x[63] = 1'b1; y[63] = 1'b1; end
        3: y = ~x;
        default: ;
      endcase
      model(x, y, es, ec, eo);
      apply(x, y);
      check($sformatf("rand%0d", i), es, ec, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
